// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bridge
// Purpose  : SPI (mode 0) slave that bridges serial frames onto a
//            byte-lane register-file port. The first byte of a frame is
//            a command (bit7 = 1 write / 0 read, low bits = byte address);
//            the following bytes are written to, or read from, consecutive
//            byte addresses with auto-increment and wrap.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            sclk, cs_n, mosi  - asynchronous SPI inputs, resynchronized
//            miso, miso_oe     - serial read data (MSB first) and its enable
//            addr_reg          - register row (byte_addr[ADDR_BITS-1:2])
//            we_reg            - one-cycle write strobe
//            wdata_reg         - data byte replicated on every lane
//            wmask_reg         - one-hot lane select (byte_addr[1:0])
//            rdata_reg         - combinational read data for addr_reg
//            frame_err         - pulse when cs_n rises mid-byte
// Options  : SPI_RD_DUMMY_EN   - when defined, a read inserts one dummy
//                                byte (miso = 0) between command and data.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef RF_AWIDTH
`define RF_AWIDTH (ADDR_BITS-2)
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif

module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   cs_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  output logic [`RF_AWIDTH-1:0]  addr_reg,
  output logic                   we_reg,
  output logic [`RF_WIDTH-1:0]   wdata_reg,
  output logic [`RF_MASK-1:0]    wmask_reg,
  input  logic [`RF_WIDTH-1:0]   rdata_reg,
  output logic                   frame_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WDATA  = 3'd2,
    S_RFETCH = 3'd3,
    S_RDATA  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;
  assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
  // A reset clears the cs_n synchronizer to 0, so a frame that was in
  // flight during reset never shows a falling edge: the bridge waits for
  // the next genuine cs_n high->low transition.
  assign w_cs_fall   = r_cs_prev & ~w_cs_s;

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift_in;
  logic [7:0]             r_shift_out;
  logic [ADDR_BITS-1:0]   r_byte_addr;
`ifdef SPI_RD_DUMMY_EN
  logic                   r_dummy;
  logic [7:0]             r_fetch_buf;
`endif

  logic [7:0]             w_byte;
  logic [ADDR_BITS-1:0]   w_addr_inc;
  logic [7:0]             w_rd_lane;

  // Byte being completed on this rising edge (7 earlier bits + current bit).
  assign w_byte     = {r_shift_in, w_mosi_s};
  assign w_addr_inc = r_byte_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
  assign w_rd_lane  = rdata_reg[{r_byte_addr[1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_byte_addr <= '0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      wmask_reg   <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SPI_RD_DUMMY_EN
      r_dummy     <= 1'b0;
      r_fetch_buf <= 8'd0;
`endif
    end else begin
      we_reg    <= 1'b0;
      frame_err <= 1'b0;

      if (w_cs_s) begin
        // Deselect wins over everything, including a byte completing in
        // the same cycle; only a partially shifted byte is an error.
        if (r_state != S_IDLE) begin
          r_state <= S_IDLE;
          if (r_bit_cnt != 3'd0) begin
            frame_err <= 1'b1;
          end
        end
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_state     <= S_CMD;
          r_bit_cnt   <= 3'd0;
          r_shift_in  <= 7'd0;
          r_shift_out <= 8'd0;
          miso        <= 1'b0;
          miso_oe     <= 1'b1;
`ifdef SPI_RD_DUMMY_EN
          r_dummy     <= 1'b0;
`endif
        end
      end else begin
        // Sample MOSI on SCLK rising.
        if (w_sclk_rise) begin
          r_shift_in <= w_byte[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            case (r_state)
              S_CMD: begin
                r_byte_addr <= w_byte[ADDR_BITS-1:0];
                addr_reg    <= w_byte[ADDR_BITS-1:2];
                if (w_byte[7]) begin
                  r_state <= S_WDATA;
                end else begin
                  r_state <= S_RFETCH;
`ifdef SPI_RD_DUMMY_EN
                  r_dummy <= 1'b1;
`endif
                end
              end
              S_WDATA: begin
                we_reg      <= 1'b1;
                addr_reg    <= r_byte_addr[ADDR_BITS-1:2];
                wmask_reg   <= 4'b0001 << r_byte_addr[1:0];
                wdata_reg   <= {4{w_byte}};
                r_byte_addr <= w_addr_inc;
              end
              S_RDATA: begin
`ifdef SPI_RD_DUMMY_EN
                if (r_dummy) begin
                  // End of dummy byte: the first data byte was already
                  // fetched while the dummy byte was shifting.
                  r_shift_out <= r_fetch_buf;
                  r_dummy     <= 1'b0;
                end else begin
                  r_byte_addr <= w_addr_inc;
                  addr_reg    <= w_addr_inc[ADDR_BITS-1:2];
                  r_state     <= S_RFETCH;
                end
`else
                r_byte_addr <= w_addr_inc;
                addr_reg    <= w_addr_inc[ADDR_BITS-1:2];
                r_state     <= S_RFETCH;
`endif
              end
              default: ;
            endcase
          end
        end

        // Shift MISO on SCLK falling. The 8th falling edge of a byte
        // presents the MSB of the freshly loaded next byte.
        if (w_sclk_fall) begin
          miso        <= r_shift_out[7];
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end

        // addr_reg was driven on entry; rdata_reg is valid now.
        if (r_state == S_RFETCH) begin
          r_state <= S_RDATA;
`ifdef SPI_RD_DUMMY_EN
          if (r_dummy) begin
            r_fetch_buf <= w_rd_lane;
          end else begin
            r_shift_out <= w_rd_lane;
          end
`else
          r_shift_out <= w_rd_lane;
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk, cs_n and mosi.
REQ-002 SHALL have parameter ADDR_BITS, default 7: byte-address field width in the command byte.
REQ-003 SHALL have port clk, input, 1: system clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports sclk, cs_n and mosi, input, 1 each: SPI mode 0, asynchronous to clk.
REQ-006 SHALL have port miso, output, 1: serial read data, MSB first.
REQ-007 SHALL have port miso_oe, output, 1: high while synchronized cs_n is low.
REQ-008 SHALL have port addr_reg, output, `RF_AWIDTH: register row, equal to byte_addr[ADDR_BITS-1:2].
REQ-009 SHALL have port we_reg, output, 1: write strobe.
REQ-010 SHALL have port wdata_reg, output, `RF_WIDTH: the data byte replicated on every lane.
REQ-011 SHALL have port wmask_reg, output, `RF_MASK: one-hot byte-lane select, equal to byte_addr[1:0].
REQ-012 SHALL have port rdata_reg, input, `RF_WIDTH: read data, combinational from addr_reg.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse when a frame aborts mid-byte.

Function
REQ-014 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops, and SHALL detect sclk edges from the last two synchronized samples; clk >= 8x sclk.
REQ-015 SHALL use FSM states IDLE, CMD, WDATA, RFETCH, RDATA.
REQ-016 IDLE -> CMD on cs_n falling; the bit counter clears.
REQ-017 SHALL sample mosi on sclk rising and shift MISO on sclk falling.
REQ-018 CMD byte: bit7 = 1 write / 0 read; bits[6:0] = byte_addr. After the 8th bit: write -> WDATA, read -> RFETCH.
REQ-019 WDATA: after each 8th bit, we_reg SHALL be high for exactly one clk, with addr_reg, wmask_reg and wdata_reg valid in that same cycle; byte_addr then increments.
REQ-020 RFETCH: SHALL drive addr_reg, register rdata_reg byte lane byte_addr[1:0] one clk later, load the shift register, then go to RDATA; total at most 3 clk.
REQ-021 RDATA: SHALL output the loaded byte MSB first, starting at the 8th falling edge of the previous byte; at each byte end SHALL increment byte_addr and refetch.
REQ-022 byte_addr SHALL wrap 127 -> 0, and lane 3 -> lane 0 of the next row.
REQ-023 cs_n rising SHALL return to IDLE from any state within 1 clk after synchronization, and SHALL override a simultaneous byte completion.
REQ-024 A partial byte (bit count 1..7) at cs_n rising SHALL be discarded with no write, and SHALL pulse frame_err.
REQ-025 we_reg SHALL never assert in CMD, RFETCH, RDATA or IDLE.
REQ-026 miso SHALL be 0 whenever miso_oe is low.
REQ-027 A command byte-only frame SHALL produce no write.

Reset
REQ-028 rst SHALL force IDLE and set all outputs to 0: addr_reg, we_reg, wdata_reg, wmask_reg, miso, miso_oe, frame_err.
REQ-029 rst SHALL also zero the synchronizers, bit counter, shift registers and byte_addr.
REQ-030 rst mid-frame SHALL abort the frame; the bridge SHALL resume only on the next cs_n falling edge.

Configuration
REQ-031 Macro SPI_RD_DUMMY_EN defined: a read SHALL insert one dummy byte after the command, during which miso is 0; the fetch SHALL occur during the dummy byte and the first data byte SHALL follow it.
REQ-032 Macro SPI_RD_DUMMY_EN undefined: the first read data byte SHALL immediately follow the command byte, per REQ-020/021.

Verification
REQ-033 Write frame: cmd 0x8C, data 0x34, 0x12 -> we_reg pulses twice: addr_reg 3, wmask 0001, byte 0x34; then wmask 0010, byte 0x12.
REQ-034 Read frame: cmd 0x04, rdata_reg[1] = 0xAABBCCDD, rdata_reg[2] = 0x11223344, 5 bytes clocked -> miso returns 0xDD CC BB AA 44; with SPI_RD_DUMMY_EN, 0x00 precedes them.
REQ-035 Wrap: cmd 0xFF, data 0x5A, 0xA5 -> writes to row 31 lane 3, then row 0 lane 0.
REQ-036 Abort: cmd 0x80 plus 5 data bits, then cs_n rises -> no we_reg, frame_err pulses once, FSM in IDLE.
REQ-037 Reset: rst asserted for 1 clk during WDATA bit 4 -> all outputs 0; a following full write frame completes correctly.
REQ-038 Timing: sclk = clk/8, cs_n high between frames for 2 sclk periods -> every transfer is correct, and miso is 0 while cs_n is high.
